data_bus_bridge: RTL

Sits between the LSU data port and the dual-port `ram` data port. It decodes each LSU access to either RAM or the simulation peripheral window, and adds a registered read-response handshake. It also buffers character-out writes in a FIFO, drained at a paced rate to the simulation console, and latches the simulation halt/exit code. Instruction fetch does not pass through this block.

---
 rtl/data_bus_bridge_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/data_bus_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/data_bus_bridge_pkg.sv
// Shared address map and payload types for the LSU data-side bridge.
package data_bus_bridge_pkg;

    localparam logic [31:0] PERIPH_BASE   = 32'h0002_0000;
    localparam logic [31:0] CHAR_OUT_ADDR = 32'h0002_0000;
    localparam logic [31:0] SIM_CTRL_ADDR = 32'h0002_0002;

    // Peripheral registers are byte lanes within the single peripheral word.
    localparam int unsigned CHAR_LANE     = 32'(CHAR_OUT_ADDR[1:0]);
    localparam int unsigned SIM_CTRL_LANE = 32'(SIM_CTRL_ADDR[1:0]);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic is_periph(input logic [31:0] addr);
        return addr[31:2] == PERIPH_BASE[31:2];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/data_bus_bridge.sv
// LSU data-port bridge: RAM/peripheral decode, registered read response,
// paced console character FIFO and simulation halt/exit-code latch.
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DRAIN_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        sim_halt_o,
    output logic [7:0]  sim_exit_code_o,
    output logic        sim_done_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DRAIN_DIV) + 1;

    lsu_req_t      lsu_req;
    logic          periph;
    logic          xfer;
    logic          rd_xfer;
    logic          char_push;
    logic          char_pop;
    logic          ctrl_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic [31:0]   status;
    logic [PW-1:0] pace_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          halt_q;
    logic [7:0]    exit_code_q;

    assign lsu_req = '{we: we_i, addr: addr_i, sel: sel_i, wdata: wdata_i};

    // Decode and grant; only a char write into a full FIFO is stalled.
    assign periph    = is_periph(lsu_req.addr);
    assign gnt_o     = !(periph && lsu_req.we && lsu_req.sel[CHAR_LANE] && fifo_full);
    assign xfer      = req_i && gnt_o;
    assign rd_xfer   = xfer && !lsu_req.we;
    assign char_push = xfer && periph && lsu_req.we && lsu_req.sel[CHAR_LANE];
    assign ctrl_wr   = xfer && periph && lsu_req.we && lsu_req.sel[SIM_CTRL_LANE];

    assign ram_ce_o    = xfer && !periph;
    assign ram_we_o    = lsu_req.we && !halt_q;
    assign ram_addr_o  = lsu_req.addr;
    assign ram_sel_o   = lsu_req.sel;
    assign ram_wdata_o = lsu_req.wdata;

    assign status = {16'h0, 8'(fifo_count), 7'h0, halt_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_xfer;
            if (rd_xfer) begin
                rdata_q <= periph ? status : ram_rdata_i;
            end
        end
    end

    // Halt is sticky; a later SIM_CTRL write only replaces the exit code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_q      <= 1'b0;
            exit_code_q <= '0;
        end else if (ctrl_wr) begin
            halt_q      <= 1'b1;
            exit_code_q <= lsu_req.wdata[8*SIM_CTRL_LANE +: 8];
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_char_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (char_push),
        .pop    (char_pop),
        .wdata  (lsu_req.wdata[8*CHAR_LANE +: 8]),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Console pacing: after each accepted char wait DRAIN_DIV-1 idle cycles.
    assign char_valid_o = !fifo_empty && (pace_q == '0);
    assign char_pop     = char_valid_o && char_ready_i;
    assign char_o       = fifo_head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pace_q <= '0;
        end else if (char_pop) begin
            pace_q <= PW'(DRAIN_DIV - 1);
        end else if (pace_q != '0) begin
            pace_q <= pace_q - PW'(1);
        end
    end

    assign rvalid_o        = rvalid_q;
    assign rdata_o         = rdata_q;
    assign sim_halt_o      = halt_q;
    assign sim_exit_code_o = exit_code_q;
    assign sim_done_o      = halt_q && fifo_empty;

endmodule
